pmesh_store_issuer: RTL and testbench
=====================================

# pmesh_store_issuer

Downstream consumer of the AXI-strobe splitter. It takes each naturally aligned store piece (one-hot-style size mask plus byte offset) together with the AXI write beat's address, data and ID, and builds a P-Mesh store request. It tracks outstanding P-Mesh acknowledgements and returns one AXI B response per beat once every piece of that beat has been acknowledged.

## Interface
Parameters:
- ADDR_W, 40, physical address width on P-Mesh.
- ID_W, 6, AXI ID width.
- MAX_OUTSTANDING, 4, maximum unacknowledged pieces in flight (≥1, ≤15).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_piece_valid  in  1  piece available from the splitter.
- s_piece_ready  out  1  piece accepted when valid & ready.
- s_piece_size  in  8  size mask: 8'h80=1B, 8'hC0=2B, 8'hF0=4B, 8'hFF=8B.
- s_piece_offset  in  3  byte offset of the piece within the 8-byte word.
- s_piece_last  in  1  final piece of the current beat.
- s_beat_addr  in  ADDR_W  beat address; bits [2:0] are ignored.
- s_beat_data  in  64  AXI write data for the beat, little-endian lanes.
- s_beat_id  in  ID_W  AXI write ID.
- pmesh_req_val  out  1  store request valid.
- pmesh_req_rdy  in  1  NoC accepts the request.
- pmesh_req_addr  out  ADDR_W  {s_beat_addr[ADDR_W-1:3], s_piece_offset}.
- pmesh_req_size  out  3  1B=3'b001, 2B=3'b010, 4B=3'b011, 8B=3'b100.
- pmesh_req_data  out  64  store data.
- pmesh_ack_val  in  1  one-cycle store acknowledge; always accepted.
- m_axi_bvalid  out  1  write response valid.
- m_axi_bready  in  1  response accepted.
- m_axi_bid  out  ID_W  ID of the completed beat.
- m_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.

## Operation
- Single-entry request register holds addr, size and data. An accepted piece loads the register; the register clears on pmesh_req_val & pmesh_req_rdy.
- s_piece_ready = (state==COLLECT) & (register empty | req handshake this cycle) & (outstanding < MAX_OUTSTANDING).
- Outstanding counter (4 bits): +1 on req handshake, −1 on pmesh_ack_val. Both in the same cycle leaves it unchanged. An ack while the counter is 0 is ignored and sets the sticky err flag.
- Illegal size mask (any other value): the request goes out as 8B with offset 0, and err is set.
- Offset misaligned for its size (e.g. 4B at offset 2): the request is sent unchanged and err is set.
- Beat ID is latched on the first accepted piece of a beat.
- FSM:
  - COLLECT → DRAIN when a piece with s_piece_last=1 is accepted.
  - DRAIN → BRESP when the register is empty and outstanding==0.
  - BRESP → COLLECT on m_axi_bvalid & m_axi_bready; err clears on that transition.
- m_axi_bvalid = (state==BRESP). m_axi_bresp = err ? SLVERR : OKAY.
- Reset values: pmesh_req_val=0, m_axi_bvalid=0, m_axi_bresp=0, m_axi_bid=0, pmesh_req_addr/size/data=0, s_piece_ready=0 during reset, counter=0, err=0, state=COLLECT.
- Reset mid-operation drops all in-flight state. Acks arriving afterwards hit the zero-counter rule and set err.

## Timing
- Piece accepted in cycle N → pmesh_req_val high in N+1; back-to-back issue at one piece per cycle while pmesh_req_rdy=1 and credit remains.
- pmesh_req_val, once high, holds with stable payload until pmesh_req_rdy.
- The ack that brings the counter to 0 in DRAIN (with the register empty) in cycle M → m_axi_bvalid in M+1.
- m_axi_bvalid holds with stable bid/bresp until m_axi_bready. The next beat's first piece can be accepted in the cycle after the B handshake.
- Credit is not released combinationally: an ack in cycle N frees a slot for acceptance in N+1.

## Configuration
- PMESH_STORE_BYTESWAP_EN defined: pmesh_req_data is s_beat_data byte-reversed (lane 0 → bits [63:56]), converting AXI little-endian to P-Mesh big-endian. The address offset is unchanged.
- PMESH_STORE_BYTESWAP_EN undefined: s_beat_data passes through unchanged.

## Structure
- Shared package holds:
  - size-mask constants (BASE_1B/2B/4B/8B),
  - P-Mesh size codes,
  - AXI bresp codes,
  - the issuer FSM state enum.
- One sub-module, pmesh_size_encode: combinational mask+offset → {size code, illegal, misaligned}. Everything else is inline.

## Test plan
- Single 8B piece (size 8'hFF, offset 0, last=1, addr 0x1000, id 5) → request addr 0x1000, size 3'b100. After its ack: bvalid with bid=5, bresp=OKAY.
- Strobe split into 3 pieces (1B@1, 2B@2, 4B@4, last on the third) → three consecutive requests at addr+1/+2/+4 with sizes 001/010/011. bvalid only one cycle after the third ack.
- MAX_OUTSTANDING=2, no acks → s_piece_ready drops after 2 issued pieces. One ack → ready returns the next cycle.
- Illegal size 8'hA0 → request size 3'b100 at offset 0; bresp=SLVERR. The next clean beat returns OKAY.
- Spurious ack with counter 0, plus an ack coinciding with a req handshake → counter unchanged in the coincident case; err set for the spurious ack.
- Byte swap on, data 0x0807060504030201 → pmesh_req_data 0x0102030405060708. Byte swap off → passed through.

Source files
------------

// File: rtl/pmesh_store_issuer_pkg.sv
// Shared constants and types for the P-Mesh store issuer.
package pmesh_store_issuer_pkg;

   localparam logic [7:0] BASE_1B = 8'h80;
   localparam logic [7:0] BASE_2B = 8'hC0;
   localparam logic [7:0] BASE_4B = 8'hF0;
   localparam logic [7:0] BASE_8B = 8'hFF;

   localparam logic [2:0] PMESH_SIZE_1B = 3'b001;
   localparam logic [2:0] PMESH_SIZE_2B = 3'b010;
   localparam logic [2:0] PMESH_SIZE_4B = 3'b011;
   localparam logic [2:0] PMESH_SIZE_8B = 3'b100;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      StCollect = 2'd0,
      StDrain   = 2'd1,
      StBresp   = 2'd2
   } issuer_state_e;

endpackage

// File: rtl/pmesh_size_encode.sv
// Maps a splitter size mask and byte offset onto a P-Mesh size code plus error flags.
module pmesh_size_encode
   import pmesh_store_issuer_pkg::*;
(
   input  logic [7:0] i_mask,
   input  logic [2:0] i_offset,
   output logic [2:0] o_size,
   output logic       o_illegal,
   output logic       o_misaligned
);

   always_comb begin
      o_size       = PMESH_SIZE_8B;
      o_illegal    = 1'b0;
      o_misaligned = 1'b0;
      case (i_mask)
         BASE_1B: o_size = PMESH_SIZE_1B;
         BASE_2B: begin
            o_size       = PMESH_SIZE_2B;
            o_misaligned = i_offset[0];
         end
         BASE_4B: begin
            o_size       = PMESH_SIZE_4B;
            o_misaligned = |i_offset[1:0];
         end
         BASE_8B: o_misaligned = |i_offset;
         // Unknown masks fall back to a full-word store at offset 0.
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pmesh_store_issuer.sv
// Turns aligned AXI store pieces into P-Mesh store requests and returns one B response per beat.
// Optional PMESH_STORE_BYTESWAP_EN reverses data byte lanes for a big-endian NoC.
module pmesh_store_issuer
   import pmesh_store_issuer_pkg::*;
#(
   parameter int unsigned ADDR_W          = 40,
   parameter int unsigned ID_W            = 6,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_piece_valid,
   output logic              s_piece_ready,
   input  logic [7:0]        s_piece_size,
   input  logic [2:0]        s_piece_offset,
   input  logic              s_piece_last,
   input  logic [ADDR_W-1:0] s_beat_addr,
   input  logic [63:0]       s_beat_data,
   input  logic [ID_W-1:0]   s_beat_id,
   output logic              pmesh_req_val,
   input  logic              pmesh_req_rdy,
   output logic [ADDR_W-1:0] pmesh_req_addr,
   output logic [2:0]        pmesh_req_size,
   output logic [63:0]       pmesh_req_data,
   input  logic              pmesh_ack_val,
   output logic              m_axi_bvalid,
   input  logic              m_axi_bready,
   output logic [ID_W-1:0]   m_axi_bid,
   output logic [1:0]        m_axi_bresp
);

   localparam logic [4:0] MAX_CNT = 5'(MAX_OUTSTANDING);

   issuer_state_e     r_state;
   logic              r_req_val;
   logic [ADDR_W-1:0] r_req_addr;
   logic [2:0]        r_req_size;
   logic [63:0]       r_req_data;
   logic [3:0]        r_cnt;
   logic              r_err;
   logic              r_first;
   logic [ID_W-1:0]   r_bid;
   logic [1:0]        r_bresp;

   logic [2:0]        w_size;
   logic              w_illegal;
   logic              w_misaligned;
   logic [ADDR_W-1:0] w_addr;
   logic [63:0]       w_data;
   logic              w_req_hs;
   logic              w_accept;
   logic              w_spurious;
   logic              w_cnt_dec;
   logic              w_bhs;
   logic              w_req_empty_d;
   logic [4:0]        w_inflight;
   logic [3:0]        w_cnt_d;
   logic              w_err_d;
   logic              w_unused;

   pmesh_size_encode u_size_encode (
      .i_mask       (s_piece_size),
      .i_offset     (s_piece_offset),
      .o_size       (w_size),
      .o_illegal    (w_illegal),
      .o_misaligned (w_misaligned)
   );

   assign w_unused = ^s_beat_addr[2:0];
   assign w_addr   = {s_beat_addr[ADDR_W-1:3], w_illegal ? 3'b000 : s_piece_offset};

`ifdef PMESH_STORE_BYTESWAP_EN
   always_comb begin
      w_data = '0;
      for (int i = 0; i < 8; i++) begin
         w_data[(7-i)*8 +: 8] = s_beat_data[i*8 +: 8];
      end
   end
`else
   assign w_data = s_beat_data;
`endif

   assign w_req_hs   = r_req_val & pmesh_req_rdy;
   assign w_spurious = pmesh_ack_val & (r_cnt == 4'd0);
   assign w_cnt_dec  = pmesh_ack_val & ~w_spurious;
   assign w_bhs      = (r_state == StBresp) & m_axi_bready;

   // A piece parked in the request register already holds a credit.
   assign w_inflight = {1'b0, r_cnt} + {4'd0, r_req_val};

   assign s_piece_ready = ~rst & (r_state == StCollect) & (~r_req_val | w_req_hs) &
                          (w_inflight < MAX_CNT);
   assign w_accept      = s_piece_valid & s_piece_ready;

   // No piece is accepted outside COLLECT, so only the handshake can empty the register.
   assign w_req_empty_d = ~r_req_val | w_req_hs;

   always_comb begin
      w_cnt_d = r_cnt;
      case ({w_req_hs, w_cnt_dec})
         2'b10:   w_cnt_d = r_cnt + 4'd1;
         2'b01:   w_cnt_d = r_cnt - 4'd1;
         default: w_cnt_d = r_cnt;
      endcase
   end

   always_comb begin
      w_err_d = r_err;
      if (w_bhs) begin
         w_err_d = 1'b0;
      end
      if (w_spurious | (w_accept & (w_illegal | w_misaligned))) begin
         w_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_val  <= 1'b0;
         r_req_addr <= '0;
         r_req_size <= '0;
         r_req_data <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_req_val  <= 1'b1;
            r_req_addr <= w_addr;
            r_req_size <= w_size;
            r_req_data <= w_data;
         end else if (w_req_hs) begin
            r_req_val <= 1'b0;
         end
         r_cnt <= w_cnt_d;
         r_err <= w_err_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StCollect;
         r_first <= 1'b1;
         r_bid   <= '0;
         r_bresp <= AXI_RESP_OKAY;
      end else begin
         case (r_state)
            StCollect: begin
               if (w_accept) begin
                  r_first <= 1'b0;
                  if (r_first) begin
                     r_bid <= s_beat_id;
                  end
                  if (s_piece_last) begin
                     r_state <= StDrain;
                  end
               end
            end
            StDrain: begin
               // Look at next-cycle occupancy so bvalid follows the final ack by one cycle.
               if (w_req_empty_d && (w_cnt_d == 4'd0)) begin
                  r_state <= StBresp;
                  r_bresp <= w_err_d ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               end
            end
            StBresp: begin
               if (m_axi_bready) begin
                  r_state <= StCollect;
                  r_first <= 1'b1;
               end
            end
            default: r_state <= StCollect;
         endcase
      end
   end

   assign pmesh_req_val  = r_req_val;
   assign pmesh_req_addr = r_req_addr;
   assign pmesh_req_size = r_req_size;
   assign pmesh_req_data = r_req_data;
   assign m_axi_bvalid   = (r_state == StBresp);
   assign m_axi_bid      = r_bid;
   assign m_axi_bresp    = r_bresp;

endmodule

// File: tb/tb_pmesh_store_issuer.sv
// Randomised bench for pmesh_store_issuer against a transaction-level reference model.
module tb_pmesh_store_issuer;

   localparam int MAX_OUT = 2;
   localparam int P_COLLECT = 0;
   localparam int P_DRAIN   = 1;
   localparam int P_BRESP   = 2;

   typedef struct {
      logic [39:0] addr;
      logic [2:0]  size;
      logic [63:0] data;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        d_pv;
   logic [7:0]  d_size;
   logic [2:0]  d_off;
   logic        d_last;
   logic [39:0] d_addr;
   logic [63:0] d_data;
   logic [5:0]  d_id;
   logic        d_rdy;
   logic        d_ack;
   logic        d_bready;

   logic        s_piece_ready;
   logic        pmesh_req_val;
   logic [39:0] pmesh_req_addr;
   logic [2:0]  pmesh_req_size;
   logic [63:0] pmesh_req_data;
   logic        m_axi_bvalid;
   logic [5:0]  m_axi_bid;
   logic [1:0]  m_axi_bresp;

   int n_checks = 0;
   int n_pass   = 0;
   int rdy_pct, ack_pct, spur_pct;

   req_t        q_req[$];
   int          m_outst;
   int          m_phase;
   bit          m_err;
   bit          m_first;
   logic [5:0]  m_bid;
   logic [1:0]  m_bresp;

   always #5 clk = ~clk;

   pmesh_store_issuer #(
      .ADDR_W          (40),
      .ID_W            (6),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_piece_valid  (d_pv),
      .s_piece_ready  (s_piece_ready),
      .s_piece_size   (d_size),
      .s_piece_offset (d_off),
      .s_piece_last   (d_last),
      .s_beat_addr    (d_addr),
      .s_beat_data    (d_data),
      .s_beat_id      (d_id),
      .pmesh_req_val  (pmesh_req_val),
      .pmesh_req_rdy  (d_rdy),
      .pmesh_req_addr (pmesh_req_addr),
      .pmesh_req_size (pmesh_req_size),
      .pmesh_req_data (pmesh_req_data),
      .pmesh_ack_val  (d_ack),
      .m_axi_bvalid   (m_axi_bvalid),
      .m_axi_bready   (d_bready),
      .m_axi_bid      (m_axi_bid),
      .m_axi_bresp    (m_axi_bresp)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] exp_data(input logic [63:0] d);
      logic [63:0] r;
      r = d;
`ifdef PMESH_STORE_BYTESWAP_EN
      for (int i = 0; i < 8; i++) r[(7-i)*8 +: 8] = d[i*8 +: 8];
`endif
      return r;
   endfunction

   // Request content from the piece rules: byte count from the mask, aligned offset check.
   function automatic req_t model_req(input logic [7:0] mask, input logic [2:0] off,
                                      input logic [39:0] base, input logic [63:0] data,
                                      output bit bad);
      req_t r;
      int   nb;
      int   o;
      case (mask)
         8'h80:   nb = 1;
         8'hC0:   nb = 2;
         8'hF0:   nb = 4;
         8'hFF:   nb = 8;
         default: nb = 0;
      endcase
      o = int'(off);
      if (nb == 0) begin
         bad = 1'b1;
         o   = 0;
         r.size = 3'd4;
      end else begin
         bad = (o % nb) != 0;
         r.size = 3'($clog2(nb) + 1);
      end
      r.addr = ((base >> 3) << 3) + 40'(o);
      r.data = exp_data(data);
      return r;
   endfunction

   task automatic model_reset();
      q_req.delete();
      m_outst = 0;
      m_phase = P_COLLECT;
      m_err   = 1'b0;
      m_first = 1'b1;
      m_bid   = '0;
      m_bresp = 2'b00;
   endtask

   // Check one cycle's outputs, then advance the model by that cycle's handshakes.
   task automatic step(output bit acc);
      bit   exp_ready;
      bit   hs;
      bit   bad;
      req_t r;
      #1;
      exp_ready = !rst && (m_phase == P_COLLECT) && (q_req.size() == 0 || d_rdy) &&
                  (m_outst + q_req.size() < MAX_OUT);
      check("ready", 64'(s_piece_ready), 64'(exp_ready));
      check("req_val", 64'(pmesh_req_val), 64'(q_req.size() != 0));
      if (q_req.size() != 0) begin
         check("req_addr", 64'(pmesh_req_addr), 64'(q_req[0].addr));
         check("req_size", 64'(pmesh_req_size), 64'(q_req[0].size));
         check("req_data", pmesh_req_data, q_req[0].data);
      end
      check("bvalid", 64'(m_axi_bvalid), 64'(m_phase == P_BRESP));
      if (m_phase == P_BRESP) begin
         check("bid", 64'(m_axi_bid), 64'(m_bid));
         check("bresp", 64'(m_axi_bresp), 64'(m_bresp));
      end
      acc = d_pv && s_piece_ready;
      if (!rst) begin
         hs = (q_req.size() != 0) && d_rdy;
         if (m_phase == P_BRESP && d_bready) begin
            m_phase = P_COLLECT;
            m_err   = 1'b0;
            m_first = 1'b1;
         end
         if (d_ack) begin
            if (m_outst == 0) m_err = 1'b1;
            else m_outst--;
         end
         if (hs) begin
            void'(q_req.pop_front());
            m_outst++;
         end
         if (d_pv && exp_ready) begin
            r = model_req(d_size, d_off, d_addr, d_data, bad);
            q_req.push_back(r);
            if (bad) m_err = 1'b1;
            if (m_first) m_bid = d_id;
            m_first = 1'b0;
            if (d_last) m_phase = P_DRAIN;
         end
         if (m_phase == P_DRAIN && q_req.size() == 0 && m_outst == 0) begin
            m_phase = P_BRESP;
            m_bresp = m_err ? 2'b10 : 2'b00;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_bg();
      d_rdy    = ($urandom_range(0, 99) < rdy_pct);
      d_ack    = (m_outst > 0) ? ($urandom_range(0, 99) < ack_pct)
                               : ($urandom_range(0, 99) < spur_pct);
      d_bready = ($urandom_range(0, 99) < 50);
   endtask

   task automatic send_piece(input logic [7:0] mask, input logic [2:0] off, input bit last);
      bit acc;
      acc    = 1'b0;
      d_pv   = 1'b1;
      d_size = mask;
      d_off  = off;
      d_last = last;
      for (int c = 0; c < 200 && !acc; c++) begin
         drive_bg();
         step(acc);
      end
      d_pv = 1'b0;
      if (!acc) check("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic wait_done();
      bit acc;
      bit done;
      done = (m_phase == P_COLLECT);
      for (int c = 0; c < 400 && !done; c++) begin
         drive_bg();
         step(acc);
         done = (m_phase == P_COLLECT);
      end
      if (!done) check("bresp_timeout", 64'(done), 64'd1);
   endtask

   task automatic new_beat(input logic [39:0] a, input logic [5:0] id, input logic [63:0] d);
      d_addr = a;
      d_id   = id;
      d_data = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit          acc;
      int          n_acc;
      logic [7:0]  mask;
      logic [2:0]  off;
      int          npieces;
      int          kind;

      rst = 1'b1;
      d_pv = 1'b0; d_size = '0; d_off = '0; d_last = 1'b0;
      d_addr = '0; d_data = '0; d_id = '0;
      d_rdy = 1'b0; d_ack = 1'b0; d_bready = 1'b0;
      rdy_pct = 100; ack_pct = 100; spur_pct = 0;
      model_reset();
      repeat (2) @(negedge clk);
      d_pv = 1'b1;
      #1;
      check("rst_ready", 64'(s_piece_ready), 64'd0);
      check("rst_req_val", 64'(pmesh_req_val), 64'd0);
      check("rst_bvalid", 64'(m_axi_bvalid), 64'd0);
      check("rst_bid", 64'(m_axi_bid), 64'd0);
      check("rst_bresp", 64'(m_axi_bresp), 64'd0);
      check("rst_addr", 64'(pmesh_req_addr), 64'd0);
      check("rst_size", 64'(pmesh_req_size), 64'd0);
      check("rst_data", pmesh_req_data, 64'd0);
      d_pv = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Single full-word store.
      new_beat(40'h1000, 6'd5, 64'h0807060504030201);
      send_piece(8'hFF, 3'd0, 1'b1);
      #1;
      check("t1_addr", 64'(pmesh_req_addr), 64'h1000);
      check("t1_size", 64'(pmesh_req_size), 64'd4);
`ifdef PMESH_STORE_BYTESWAP_EN
      check("t1_data", pmesh_req_data, 64'h0102030405060708);
`else
      check("t1_data", pmesh_req_data, 64'h0807060504030201);
`endif
      wait_done();

      // Three-piece beat.
      new_beat(40'h2_0000_0040, 6'd9, 64'hDEAD_BEEF_CAFE_F00D);
      send_piece(8'h80, 3'd1, 1'b0);
      send_piece(8'hC0, 3'd2, 1'b0);
      send_piece(8'hF0, 3'd4, 1'b1);
      wait_done();

      // Credit exhaustion with no acks, then a single ack.
      new_beat(40'h3000, 6'd12, 64'h1122_3344_5566_7788);
      d_rdy = 1'b1; d_ack = 1'b0; d_bready = 1'b0;
      d_pv = 1'b1; d_size = 8'h80; d_last = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 4; c++) begin
         d_off = 3'(n_acc);
         step(acc);
         if (acc) n_acc++;
      end
      check("credit_stall", 64'(n_acc), 64'd2);
      d_ack = 1'b1;
      step(acc);
      if (acc) n_acc++;
      d_ack = 1'b0;
      #1;
      check("credit_return", 64'(s_piece_ready), 64'd1);
      send_piece(8'h80, 3'(n_acc), 1'b0);
      send_piece(8'h80, 3'd3, 1'b1);
      wait_done();

      // Illegal mask gives SLVERR, next clean beat OKAY.
      new_beat(40'h4008, 6'd33, 64'hA5A5_5A5A_0F0F_F0F0);
      send_piece(8'hA0, 3'd5, 1'b1);
      #1;
      check("illegal_size", 64'(pmesh_req_size), 64'd4);
      check("illegal_addr", 64'(pmesh_req_addr), 64'h4008);
      wait_done();
      new_beat(40'h5000, 6'd34, 64'h0);
      send_piece(8'hF0, 3'd0, 1'b1);
      wait_done();

      // Spurious ack, then an ack coinciding with a request handshake.
      d_ack = 1'b1; d_rdy = 1'b0;
      step(acc);
      d_ack = 1'b0;
      new_beat(40'h6000, 6'd40, 64'h1234_5678_9ABC_DEF0);
      rdy_pct = 100; ack_pct = 0;
      send_piece(8'hC0, 3'd0, 1'b0);
      d_rdy = 1'b1; d_ack = 1'b0;
      step(acc);
      d_rdy = 1'b0;
      send_piece(8'hC0, 3'd2, 1'b1);
      d_rdy = 1'b1; d_ack = 1'b1;
      step(acc);
      ack_pct = 100;
      wait_done();

      // Reset mid-beat, then a late ack.
      new_beat(40'h7000, 6'd50, 64'h0F1E_2D3C_4B5A_6978);
      ack_pct = 0;
      send_piece(8'h80, 3'd0, 1'b0);
      d_rdy = 1'b1;
      step(acc);
      rst = 1'b1;
      model_reset();
      step(acc);
      rst = 1'b0;
      d_ack = 1'b1;
      step(acc);
      d_ack = 1'b0;
      ack_pct = 100;
      send_piece(8'hFF, 3'd0, 1'b1);
      wait_done();
      send_piece(8'h80, 3'd7, 1'b1);
      wait_done();

      // Randomised traffic.
      rdy_pct = 70; ack_pct = 40; spur_pct = 2;
      for (int b = 0; b < 40; b++) begin
         new_beat({$urandom, $urandom}, 6'($urandom), {$urandom, $urandom});
         npieces = $urandom_range(1, 4);
         for (int p = 0; p < npieces; p++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
               mask = 8'h81 + 8'($urandom_range(0, 60));
               off  = 3'($urandom);
            end else begin
               case ($urandom_range(0, 3))
                  0:       mask = 8'h80;
                  1:       mask = 8'hC0;
                  2:       mask = 8'hF0;
                  default: mask = 8'hFF;
               endcase
               off = 3'($urandom);
               if (kind != 1) begin
                  case (mask)
                     8'hC0:   off = off & 3'b110;
                     8'hF0:   off = off & 3'b100;
                     8'hFF:   off = 3'd0;
                     default: off = off;
                  endcase
               end
            end
            send_piece(mask, off, p == npieces - 1);
         end
         wait_done();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
